// File: rtl/debug_baud_pkg.sv
// Shared encodings and defaults for the debug-port baud controller.
// Saturating helper for the retry counter lives here so the top stays compact.
package debug_baud_pkg;

    localparam int GOOD_FRAMES_DEF  = 2;
    localparam int ERR_LIMIT_DEF    = 3;
    localparam int REARM_CYCLES_DEF = 4;

    localparam int ST_W    = 3;
    localparam int CNT_W   = 8;
    localparam int RETRY_W = 4;

    localparam logic [ST_W-1:0] ST_REARM  = 3'd0;
    localparam logic [ST_W-1:0] ST_SEARCH = 3'd1;
    localparam logic [ST_W-1:0] ST_VERIFY = 3'd2;
    localparam logic [ST_W-1:0] ST_LOCKED = 3'd3;
    localparam logic [ST_W-1:0] ST_HOST   = 3'd4;

    function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/debug_baud_ctrl.sv
// Baud selection controller for the debug UART: arbitrates autobaud results,
// verifies them against received frames and lets the debugger override or re-arm.
module debug_baud_ctrl
    import debug_baud_pkg::*;
#(
    parameter int GOOD_FRAMES  = GOOD_FRAMES_DEF,
    parameter int ERR_LIMIT    = ERR_LIMIT_DEF,
    parameter int REARM_CYCLES = REARM_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ab_wr,
    input  logic [7:0] ab_div,
    input  logic [1:0] ab_rx_sel,
    input  logic       host_wr,
    input  logic [7:0] host_div,
    input  logic [1:0] host_sel,
    input  logic       host_rearm,
    input  logic       rx_done,
    input  logic       frame_err,
    output logic [7:0] baud_div,
    output logic       baud_load,
    output logic [1:0] rx_sel,
    output logic       locked,
    output logic       ab_rst,
    output logic [3:0] retry_cnt
);

    localparam logic [CNT_W-1:0] GOOD_LIM   = CNT_W'(GOOD_FRAMES);
    localparam logic [CNT_W-1:0] ERR_LIM    = CNT_W'(ERR_LIMIT);
    localparam logic [CNT_W-1:0] REARM_LAST = CNT_W'(REARM_CYCLES - 1);

    logic [ST_W-1:0]    state_q,     state_d;
    logic [CNT_W-1:0]   rearm_cnt_q, rearm_cnt_d;
    logic [CNT_W-1:0]   good_cnt_q,  good_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q,   err_cnt_d;
    logic [RETRY_W-1:0] retry_q,     retry_d;
    logic [7:0]         div_q,       div_d;
    logic [1:0]         sel_q,       sel_d;
    logic               load_q,      load_d;
    logic               locked_q,    locked_d;

    logic [CNT_W-1:0] good_inc;
    logic [CNT_W-1:0] err_inc;

    assign good_inc = good_cnt_q + 1'b1;
    assign err_inc  = err_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        rearm_cnt_d = rearm_cnt_q;
        good_cnt_d  = good_cnt_q;
        err_cnt_d   = err_cnt_q;
        retry_d     = retry_q;
        div_d       = div_q;
        sel_d       = sel_q;
        load_d      = 1'b0;

        // Debugger override beats everything, including its own re-arm request.
        if (host_wr) begin
            div_d   = host_div;
            sel_d   = host_sel;
            load_d  = 1'b1;
            state_d = ST_HOST;
            retry_d = '0;
        end else if (host_rearm) begin
            state_d     = ST_REARM;
            rearm_cnt_d = '0;
        end else begin
            case (state_q)
                ST_REARM: begin
                    if (rearm_cnt_q == REARM_LAST) begin
                        state_d     = ST_SEARCH;
                        rearm_cnt_d = '0;
                    end else begin
                        rearm_cnt_d = rearm_cnt_q + 1'b1;
                    end
                end
                ST_SEARCH: begin
                    if (ab_wr && (ab_div != 8'd0)) begin
                        div_d      = ab_div;
                        sel_d      = ab_rx_sel;
                        load_d     = 1'b1;
                        good_cnt_d = '0;
                        err_cnt_d  = '0;
                        state_d    = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    // A frame error masks a coincident rx_done.
                    if (frame_err) begin
                        state_d     = ST_REARM;
                        rearm_cnt_d = '0;
                        retry_d     = retry_sat_inc(retry_q);
                    end else if (rx_done) begin
                        good_cnt_d = good_inc;
                        if (good_inc >= GOOD_LIM) begin
                            state_d = ST_LOCKED;
                            retry_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (frame_err) begin
                        err_cnt_d = err_inc;
                        if (err_inc >= ERR_LIM) begin
                            state_d     = ST_REARM;
                            rearm_cnt_d = '0;
                        end
                    end else if (rx_done) begin
                        err_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end

        locked_d = (state_d == ST_LOCKED) || (state_d == ST_HOST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REARM;
            rearm_cnt_q <= '0;
            good_cnt_q  <= '0;
            err_cnt_q   <= '0;
            retry_q     <= '0;
            div_q       <= '0;
            sel_q       <= '0;
            load_q      <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rearm_cnt_q <= rearm_cnt_d;
            good_cnt_q  <= good_cnt_d;
            err_cnt_q   <= err_cnt_d;
            retry_q     <= retry_d;
            div_q       <= div_d;
            sel_q       <= sel_d;
            load_q      <= load_d;
            locked_q    <= locked_d;
        end
    end

    assign baud_div  = div_q;
    assign baud_load = load_q;
    assign rx_sel    = sel_q;
    assign locked    = locked_q;
    assign retry_cnt = retry_q;
    // Detector is held in reset combinationally with rst so it never sees a stale edge.
    assign ab_rst    = rst | (state_q == ST_REARM);

endmodule

// File: tb/tb_debug_baud_ctrl.sv
// Directed plus randomized bench for debug_baud_ctrl against a cycle-level
// behavioural model of the lock/verify/override rules.
module tb_debug_baud_ctrl;

    localparam int GOOD_FRAMES  = 2;
    localparam int ERR_LIMIT    = 3;
    localparam int REARM_CYCLES = 4;

    localparam int M_REARM  = 0;
    localparam int M_SEARCH = 1;
    localparam int M_VERIFY = 2;
    localparam int M_LOCKED = 3;
    localparam int M_HOST   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ab_wr = 1'b0;
    logic [7:0] ab_div = '0;
    logic [1:0] ab_rx_sel = '0;
    logic       host_wr = 1'b0;
    logic [7:0] host_div = '0;
    logic [1:0] host_sel = '0;
    logic       host_rearm = 1'b0;
    logic       rx_done = 1'b0;
    logic       frame_err = 1'b0;
    logic [7:0] baud_div;
    logic       baud_load;
    logic [1:0] rx_sel;
    logic       locked;
    logic       ab_rst;
    logic [3:0] retry_cnt;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int         m_mode = M_REARM;
    int         m_rearm_n = 0;
    int         m_good = 0;
    int         m_errs = 0;
    logic [7:0] m_div = '0;
    logic [1:0] m_sel = '0;
    logic [3:0] m_retry = '0;
    logic       m_load = 1'b0;
    logic       m_locked = 1'b0;

    debug_baud_ctrl #(
        .GOOD_FRAMES (GOOD_FRAMES),
        .ERR_LIMIT   (ERR_LIMIT),
        .REARM_CYCLES(REARM_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ab_wr     (ab_wr),
        .ab_div    (ab_div),
        .ab_rx_sel (ab_rx_sel),
        .host_wr   (host_wr),
        .host_div  (host_div),
        .host_sel  (host_sel),
        .host_rearm(host_rearm),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .baud_div  (baud_div),
        .baud_load (baud_load),
        .rx_sel    (rx_sel),
        .locked    (locked),
        .ab_rst    (ab_rst),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies the rules to the inputs that were present at this clock edge.
    task automatic model_edge();
        if (rst) begin
            m_mode = M_REARM; m_rearm_n = 0; m_good = 0; m_errs = 0;
            m_retry = '0; m_div = '0; m_sel = '0; m_load = 1'b0; m_locked = 1'b0;
            return;
        end
        m_load = 1'b0;
        if (host_wr) begin
            m_div = host_div; m_sel = host_sel; m_load = 1'b1;
            m_mode = M_HOST; m_retry = '0;
        end else if (host_rearm) begin
            m_mode = M_REARM; m_rearm_n = 0;
        end else begin
            case (m_mode)
                M_REARM: begin
                    m_rearm_n++;
                    if (m_rearm_n == REARM_CYCLES) m_mode = M_SEARCH;
                end
                M_SEARCH: if (ab_wr && ab_div != 8'd0) begin
                    m_div = ab_div; m_sel = ab_rx_sel; m_load = 1'b1;
                    m_good = 0; m_errs = 0; m_mode = M_VERIFY;
                end
                M_VERIFY: begin
                    if (frame_err) begin
                        m_mode = M_REARM; m_rearm_n = 0;
                        if (m_retry < 4'd15) m_retry = m_retry + 4'd1;
                    end else if (rx_done) begin
                        m_good++;
                        if (m_good == GOOD_FRAMES) begin
                            m_mode = M_LOCKED; m_retry = '0;
                        end
                    end
                end
                M_LOCKED: begin
                    if (frame_err) begin
                        m_errs++;
                        if (m_errs == ERR_LIMIT) begin
                            m_mode = M_REARM; m_rearm_n = 0;
                        end
                    end else if (rx_done) begin
                        m_errs = 0;
                    end
                end
                default: ;
            endcase
        end
        m_locked = (m_mode == M_LOCKED) || (m_mode == M_HOST);
    endtask

    // One clock: model update at the edge, compare 1 time unit later, clear pulses.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("baud_div", 32'(baud_div), 32'(m_div));
        chk("baud_load", 32'(baud_load), 32'(m_load));
        chk("rx_sel", 32'(rx_sel), 32'(m_sel));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("ab_rst", 32'(ab_rst), 32'(rst || (m_mode == M_REARM)));
        chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
        ab_wr = 1'b0; host_wr = 1'b0; host_rearm = 1'b0;
        rx_done = 1'b0; frame_err = 1'b0;
    endtask

    task automatic ab_write(input logic [7:0] d, input logic [1:0] s);
        ab_wr = 1'b1; ab_div = d; ab_rx_sel = s;
        tick();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_div", 32'(baud_div), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_ab_rst", 32'(ab_rst), 32'h1);
        chk("rst_retry", 32'(retry_cnt), 32'h0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("rearm_hold", 32'(ab_rst), 32'h1);
        end
        tick();
        chk("rearm_done", 32'(ab_rst), 32'h0);

        // Basic autobaud capture and lock
        ab_write(8'h1A, 2'd2);
        chk("cap_load", 32'(baud_load), 32'h1);
        chk("cap_div", 32'(baud_div), 32'h1A);
        chk("cap_sel", 32'(rx_sel), 32'h2);
        tick();
        chk("cap_load_1cyc", 32'(baud_load), 32'h0);
        rx_done = 1'b1; tick();
        chk("verify_1", 32'(locked), 32'h0);
        rx_done = 1'b1; tick();
        chk("lock_2", 32'(locked), 32'h1);

        // Locked error run with an intervening good frame
        frame_err = 1'b1; tick();
        frame_err = 1'b1; tick();
        rx_done = 1'b1; tick();
        frame_err = 1'b1; tick();
        frame_err = 1'b1; tick();
        chk("lock_err2", 32'(locked), 32'h1);
        frame_err = 1'b1; tick();
        chk("lock_err3", 32'(locked), 32'h0);
        chk("lock_err3_abrst", 32'(ab_rst), 32'h1);
        repeat (REARM_CYCLES) tick();

        // rx_done and frame_err together in VERIFY count as an error
        ab_write(8'h22, 2'd1);
        rx_done = 1'b1; frame_err = 1'b1; tick();
        chk("both_abrst", 32'(ab_rst), 32'h1);
        chk("both_retry", 32'(retry_cnt), 32'h1);
        chk("both_locked", 32'(locked), 32'h0);
        repeat (3) begin
            tick();
            chk("both_rearm", 32'(ab_rst), 32'h1);
        end
        tick();
        chk("both_search", 32'(ab_rst), 32'h0);

        // Retry saturation, then clear on lock
        for (int i = 0; i < 16; i++) begin
            ab_write(8'(8'h30 + i), 2'd0);
            frame_err = 1'b1; tick();
            repeat (REARM_CYCLES) tick();
        end
        chk("retry_sat", 32'(retry_cnt), 32'hF);
        ab_write(8'h44, 2'd3);
        repeat (GOOD_FRAMES) begin rx_done = 1'b1; tick(); end
        chk("retry_clr", 32'(retry_cnt), 32'h0);
        chk("relock", 32'(locked), 32'h1);

        // Host override wins over a simultaneous autobaud write
        host_rearm = 1'b1; tick();
        repeat (REARM_CYCLES) tick();
        host_wr = 1'b1; host_div = 8'h40; host_sel = 2'd3;
        ab_wr = 1'b1; ab_div = 8'h10; ab_rx_sel = 2'd1;
        tick();
        chk("host_div", 32'(baud_div), 32'h40);
        chk("host_load", 32'(baud_load), 32'h1);
        chk("host_locked", 32'(locked), 32'h1);
        tick();
        ab_write(8'h11, 2'd1);
        chk("host_ign_ab", 32'(baud_div), 32'h40);
        frame_err = 1'b1; tick();
        chk("host_ign_err", 32'(locked), 32'h1);
        host_wr = 1'b1; host_div = 8'h00; host_sel = 2'd1; host_rearm = 1'b1; tick();
        chk("host_over_rearm", 32'(locked), 32'h1);
        chk("host_zero_div", 32'(baud_div), 32'h0);
        host_rearm = 1'b1; tick();
        chk("host_exit", 32'(ab_rst), 32'h1);
        tick();
        host_rearm = 1'b1; tick();
        repeat (REARM_CYCLES - 1) tick();
        chk("rearm_restart", 32'(ab_rst), 32'h1);
        tick();
        chk("rearm_restart_end", 32'(ab_rst), 32'h0);

        // Reset coincident with a capture suppresses the load
        ab_write(8'h5A, 2'd2);
        repeat (GOOD_FRAMES) begin rx_done = 1'b1; tick(); end
        host_rearm = 1'b1; tick();
        repeat (REARM_CYCLES) tick();
        rst = 1'b1; ab_wr = 1'b1; ab_div = 8'h33; ab_rx_sel = 2'd1;
        tick();
        chk("rstcap_load", 32'(baud_load), 32'h0);
        chk("rstcap_div", 32'(baud_div), 32'h0);
        chk("rstcap_abrst", 32'(ab_rst), 32'h1);
        rst = 1'b0; tick();
        chk("rstcap_load2", 32'(baud_load), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(199) == 0);
            host_wr    = ($urandom_range(39) == 0);
            host_div   = 8'($urandom);
            host_sel   = 2'($urandom);
            host_rearm = ($urandom_range(59) == 0);
            ab_wr      = ($urandom_range(5) == 0);
            ab_div     = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            ab_rx_sel  = 2'($urandom);
            rx_done    = ($urandom_range(2) == 0);
            frame_err  = ($urandom_range(7) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/debug_baud_ctrl.md
DEBUG_BAUD_CTRL -- requirements
Module: debug_baud_ctrl

Interface
REQ-001 SHALL have parameter GOOD_FRAMES, default 2: clean frames required in VERIFY before lock.
REQ-002 SHALL have parameter ERR_LIMIT, default 3: consecutive frame errors in LOCKED that force re-search.
REQ-003 SHALL have parameter REARM_CYCLES, default 4: cycles ab_rst is held high per re-arm.
REQ-004 SHALL have port clk, input, 1: single system clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports ab_wr (in, 1), ab_div (in, 8) and ab_rx_sel (in, 2): autobaud result strobe, divisor and selected RX line.
REQ-007 SHALL have ports host_wr (in, 1), host_div (in, 8) and host_sel (in, 2): debugger override strobe, divisor and RX line.
REQ-008 SHALL have port host_rearm, input, 1: debugger request to restart auto-detection.
REQ-009 SHALL have ports rx_done (in, 1) and frame_err (in, 1): UART receiver good-frame and bad-stop-bit pulses.
REQ-010 SHALL have ports baud_div (out, 8) and baud_load (out, 1): divisor and load pulse to the baud generator.
REQ-011 SHALL have ports rx_sel (out, 2), locked (out, 1) and ab_rst (out, 1): active RX line, lock flag, autobaud detector reset.
REQ-012 SHALL have port retry_cnt, output, 4: saturating count of failed lock attempts.

Function
REQ-013 SHALL implement FSM states REARM, SEARCH, VERIFY, LOCKED, HOST.
REQ-014 REARM: ab_rst=1 for exactly REARM_CYCLES cycles, then -> SEARCH; locked=0.
REQ-015 SEARCH: ab_wr with ab_div!=0 -> capture baud_div=ab_div, rx_sel=ab_rx_sel, clear good/err counters, -> VERIFY; ab_wr with ab_div==0 ignored.
REQ-016 baud_load SHALL pulse high for one cycle, the cycle after any divisor capture, with baud_div already updated.
REQ-017 VERIFY: each rx_done increments good count; good count reaching GOOD_FRAMES -> LOCKED, locked=1 same edge.
REQ-018 VERIFY: frame_err -> REARM, retry_cnt +1 (saturates at 15).
REQ-019 LOCKED: frame_err increments err count; rx_done without frame_err clears it; err count reaching ERR_LIMIT -> REARM, locked=0.
REQ-020 rx_done and frame_err in the same cycle SHALL be treated as frame_err only.
REQ-021 host_wr in any state: capture host_div/host_sel, baud_load pulse, -> HOST, locked=1; host_div==0 accepted (host responsibility).
REQ-022 host_wr SHALL win over simultaneous ab_wr and over simultaneous host_rearm.
REQ-023 HOST: ignore ab_wr, rx_done, frame_err; leave only via host_rearm -> REARM.
REQ-024 host_rearm (without host_wr) in any state SHALL -> REARM, restarting the REARM_CYCLES count if already in REARM.
REQ-025 ab_wr outside SEARCH SHALL be ignored.
REQ-026 retry_cnt SHALL clear on entry to LOCKED or HOST; baud_div/rx_sel SHALL hold their last value in REARM/SEARCH.

Reset
REQ-027 rst SHALL force state REARM with REARM counter reloaded; ab_rst=1 while rst high and through REARM.
REQ-028 Reset values: baud_div=0, baud_load=0, rx_sel=0, locked=0, retry_cnt=0, internal counters 0.
REQ-029 rst mid-operation SHALL abort any state, drop locked on the next edge, and suppress any pending baud_load.

Structure
REQ-030 State encoding and parameter defaults SHALL live in shared package debug_baud_pkg.
REQ-031 Single flat module; no sub-module, counters inline.

Verification
REQ-032 Reset, release; ab_wr div=0x1A sel=2 after REARM -> baud_load 1 cycle later, baud_div=0x1A, rx_sel=2; 2 rx_done -> locked=1.
REQ-033 In VERIFY, rx_done and frame_err same cycle -> REARM, ab_rst high 4 cycles, retry_cnt=1, locked=0.
REQ-034 LOCKED: frame_err, frame_err, rx_done, frame_err x3 -> stays locked until third consecutive error, then REARM.
REQ-035 SEARCH: host_wr div=0x40 and ab_wr div=0x10 same cycle -> baud_div=0x40, state HOST; later ab_wr ignored.
REQ-036 16 consecutive VERIFY failures -> retry_cnt=15 (saturated); then successful lock -> retry_cnt=0.
REQ-037 rst asserted the cycle of a divisor capture -> no baud_load, baud_div=0, ab_rst=1.
